// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared BCD constants and calculator FSM state encoding
package calc_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_RADIX   = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } calc_state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - single BCD digit subtractor with borrow in/out
module bcd_digit_sub
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   bin,
    output logic [BCD_DIGIT_W-1:0] d,
    output logic                   bout,
    output logic                   invalid
);

    // Five signed bits hold a - b - bin for any nibble inputs (-16..15).
    logic signed [BCD_DIGIT_W:0] diff;
    logic signed [BCD_DIGIT_W:0] diff_adj;

    // Subtract, then fold a negative difference back into 0..9 with a borrow.
    always_comb begin
        diff     = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({{BCD_DIGIT_W{1'b0}}, bin});
        diff_adj = diff + $signed((BCD_DIGIT_W+1)'(BCD_RADIX));
        if (diff < 0) begin
            d    = diff_adj[BCD_DIGIT_W-1:0];
            bout = 1'b1;
        end else begin
            d    = diff[BCD_DIGIT_W-1:0];
            bout = 1'b0;
        end
        invalid = (a > 4'd9) | (b > 4'd9);
    end

endmodule

// File: rtl/bcd_subtractor_seq.sv
// rtl/bcd_subtractor_seq.sv - digit-serial BCD magnitude subtractor with sign flag
module bcd_subtractor_seq
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0] i_num_a,
    input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0] i_num_b,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [NUM_DIGITS*BCD_DIGIT_W-1:0] o_num,
    output logic                              o_neg,
    output logic                              o_err
);

    localparam int W     = NUM_DIGITS * BCD_DIGIT_W;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    calc_state_t            state;
    logic [W-1:0]           a_sh;
    logic [W-1:0]           b_sh;
    logic [W-1:0]           res_sh;
    logic [IDX_W-1:0]       idx;
    logic                   borrow;
    logic                   err;
    logic                   neg_run;

    logic [BCD_DIGIT_W-1:0] du_a;
    logic [BCD_DIGIT_W-1:0] du_b;
    logic [BCD_DIGIT_W-1:0] du_d;
    logic                   du_bout;
    logic                   du_inv;
    logic                   last_digit;

    // The NEG pass reuses the digit unit as 0 - result LSD to form the ten's complement.
    always_comb begin
        du_a       = (state == ST_NEG) ? '0 : a_sh[BCD_DIGIT_W-1:0];
        du_b       = (state == ST_NEG) ? res_sh[BCD_DIGIT_W-1:0] : b_sh[BCD_DIGIT_W-1:0];
        last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    end

    bcd_digit_sub u_digit (
        .a       (du_a),
        .b       (du_b),
        .bin     (borrow),
        .d       (du_d),
        .bout    (du_bout),
        .invalid (du_inv)
    );

    // Control FSM: accept, subtract LSD first, optionally negate, then publish the result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            idx     <= '0;
            borrow  <= 1'b0;
            err     <= 1'b0;
            neg_run <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_num   <= '0;
            o_neg   <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        a_sh    <= i_num_a;
                        b_sh    <= i_num_b;
                        borrow  <= 1'b0;
                        idx     <= '0;
                        err     <= 1'b0;
                        neg_run <= 1'b0;
                        o_busy  <= 1'b1;
                        state   <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    res_sh <= {du_d, res_sh[W-1:BCD_DIGIT_W]};
                    a_sh   <= a_sh >> BCD_DIGIT_W;
                    b_sh   <= b_sh >> BCD_DIGIT_W;
                    err    <= err | du_inv;
                    borrow <= du_bout;
                    idx    <= idx + 1'b1;
                    if (last_digit) begin
                        if (du_bout && !(err || du_inv)) begin
                            state   <= ST_NEG;
                            idx     <= '0;
                            borrow  <= 1'b0;
                            neg_run <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_NEG: begin
                    res_sh <= {du_d, res_sh[W-1:BCD_DIGIT_W]};
                    borrow <= du_bout;
                    idx    <= idx + 1'b1;
                    if (last_digit) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    o_num  <= err ? '0 : res_sh;
                    o_neg  <= neg_run && !err;
                    o_err  <= err;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// tb/tb_bcd_subtractor_seq.sv - self-checking bench for bcd_subtractor_seq
module tb_bcd_subtractor_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_a;
    logic [15:0] num_b;
    logic        busy;
    logic        done;
    logic [15:0] num;
    logic        neg;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd_subtractor_seq #(.NUM_DIGITS(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_num_a (num_a),
        .i_num_b (num_b),
        .o_busy  (busy),
        .o_done  (done),
        .o_num   (num),
        .o_neg   (neg),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_num;
        logic        exp_neg;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Start one operation and count edges until o_done (bounded).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        start = 1'b1;
        num_a = a;
        num_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        num_a = 16'h0000;
        num_b = 16'h0000;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        do_op(v.a, v.b, lat);
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " num"}, 32'(num), 32'(v.exp_num));
        chk({tag, " neg"}, 32'(neg), 32'(v.exp_neg));
        chk({tag, " err"}, 32'(err), 32'(v.exp_err));
    endtask

    initial begin
        int lat;
        vec_t v;
        logic [15:0] ra, rb;
        int ia, ib;

        vecs[0] = '{a:16'h1234, b:16'h0567, exp_num:16'h0667, exp_neg:1'b0, exp_err:1'b0, exp_lat:5};
        vecs[1] = '{a:16'h0567, b:16'h1234, exp_num:16'h0667, exp_neg:1'b1, exp_err:1'b0, exp_lat:9};
        vecs[2] = '{a:16'h0000, b:16'h0001, exp_num:16'h0001, exp_neg:1'b1, exp_err:1'b0, exp_lat:9};
        vecs[3] = '{a:16'h9999, b:16'h9999, exp_num:16'h0000, exp_neg:1'b0, exp_err:1'b0, exp_lat:5};
        vecs[4] = '{a:16'h9999, b:16'h0000, exp_num:16'h9999, exp_neg:1'b0, exp_err:1'b0, exp_lat:5};
        vecs[5] = '{a:16'h12A4, b:16'h0001, exp_num:16'h0000, exp_neg:1'b0, exp_err:1'b1, exp_lat:5};
        vecs[6] = '{a:16'h0100, b:16'h0999, exp_num:16'h0899, exp_neg:1'b1, exp_err:1'b0, exp_lat:9};

        rst_n = 1'b0;
        start = 1'b0;
        num_a = 16'h0000;
        num_b = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset num", 32'(num), 32'h0);
        chk("reset neg", 32'(neg), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done pulse", i), 32'(done), 32'h0);
            chk($sformatf("vec%0d held num", i), 32'(num), 32'(vecs[i].exp_num));
        end

        // Start while busy is ignored.
        @(negedge clk);
        start = 1'b1;
        num_a = 16'h0500;
        num_b = 16'h0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("busy mid-op", 32'(busy), 32'h1);
        start = 1'b1;
        num_a = 16'h0001;
        num_b = 16'h0002;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ignored-start latency", 32'(lat), 32'd5);
        chk("ignored-start num", 32'(num), 32'h0400);
        chk("ignored-start neg", 32'(neg), 32'h0);
        @(posedge clk);
        #1;
        chk("ignored-start no second op", 32'(busy), 32'h0);

        // Reset in the middle of a SUB pass.
        @(negedge clk);
        start = 1'b1;
        num_a = 16'h1234;
        num_b = 16'h0567;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset busy", 32'(busy), 32'h0);
        chk("midreset done", 32'(done), 32'h0);
        chk("midreset num", 32'(num), 32'h0);
        chk("midreset neg", 32'(neg), 32'h0);
        chk("midreset err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], "post-reset");

        // Back-to-back random operands against an integer model.
        for (int k = 0; k < 12; k++) begin
            for (int d = 0; d < 4; d++) begin
                ra[d*4 +: 4] = 4'($urandom_range(0, 9));
                rb[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            ia = bcd2int(ra);
            ib = bcd2int(rb);
            v.a       = ra;
            v.b       = rb;
            v.exp_num = int2bcd((ia >= ib) ? ia - ib : ib - ia);
            v.exp_neg = (ia < ib);
            v.exp_err = 1'b0;
            v.exp_lat = (ia < ib) ? 9 : 5;
            run_vec(v, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
